maze_job_sched: RTL and testbench

- Shares one maze-solver instance (bit-serial 15x15 maze in; path coordinates or not-valid flag out) between N requesters.
- Round-robin arbitration grants one requester, streams its 225 maze bits into the solver, then routes the solver's output burst back, tagged with the requester id.
- Re-arms the solver with a reset pulse between jobs and aborts hung jobs with a watchdog.
- Sits between the requester fabric and the solver; the solver is instantiated beside it, not inside it.

---
 rtl/maze_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/maze_job_sched.sv | 170 +++++++++++++++++
 tb/tb_maze_job_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_sched_pkg.sv
// Shared types for the maze job scheduler: FSM states, solver geometry and the response record.
// Pure declarations; no logic, no latency, no flow control.
package maze_sched_pkg;

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int MAZE_BITS_DFLT = 225;
    localparam int COORD_W        = 4;
    localparam int RSP_ID_W       = 3;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic                not_valid;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request at or after ptr_i, wrapping; one-hot grant plus index.
// Purely combinational, zero latency; no backpressure, the caller decides when to latch.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr_i) + i) % N_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/maze_job_sched.sv
// Time-shares one maze solver among N_REQ requesters: arbitrate, stream maze, forward result burst.
// Responses lag solver beats by 1 cycle; requesters wait on level req until granted, no other stall.
module maze_job_sched
    import maze_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAZE_BITS = MAZE_BITS_DFLT,
    parameter int TIMEOUT   = 1024,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_maze,
    output logic [N_REQ-1:0]   gnt,
    output logic               load_en,
    output logic               slv_rst_n,
    output logic               slv_maze,
    output logic               slv_in_valid,
    input  logic               slv_out_valid,
    input  logic               slv_not_valid,
    input  logic [3:0]         slv_x,
    input  logic [3:0]         slv_y,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [3:0]         rsp_x,
    output logic [3:0]         rsp_y,
    output logic               rsp_not_valid,
    output logic               rsp_last,
    output logic               rsp_err,
    output logic               busy
);

    localparam int BIT_W  = $clog2(MAZE_BITS);
    localparam int WDOG_W = $clog2(TIMEOUT);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [ID_W-1:0]  gnt_idx_q;
    logic [ID_W-1:0]  ptr_q;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic             load_en_q;
    logic             slv_rst_n_q;
    logic             rsp_valid_q;
    logic             rsp_last_q;
    logic             rsp_err_q;
    logic             busy_q;
    rsp_t             rsp_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic             id_unused;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign bit_cnt_d = bit_cnt_q + 1'b1;
    assign wdog_d    = wdog_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARM;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            ptr_q       <= '0;
            bit_cnt_q   <= '0;
            wdog_q      <= '0;
            load_en_q   <= 1'b0;
            slv_rst_n_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                // The solver's input counter only clears on its reset, so every job passes through here.
                ST_ARM: begin
                    slv_rst_n_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q     <= arb_gnt;
                        gnt_idx_q <= arb_idx;
                        rsp_q.id  <= RSP_ID_W'(arb_idx);
                        bit_cnt_q <= '0;
                        load_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_cnt_q == BIT_W'(MAZE_BITS - 1)) begin
                        load_en_q <= 1'b0;
                        wdog_q    <= '0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wdog_q <= wdog_d;
                    if (slv_out_valid) begin
                        rsp_q.x         <= slv_x;
                        rsp_q.y         <= slv_y;
                        rsp_q.not_valid <= slv_not_valid;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= ST_DRAIN;
                    end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                        rsp_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                // Watchdog keeps counting from WAIT so a stuck-high out_valid is also bounded.
                ST_DRAIN: begin
                    wdog_q <= wdog_d;
                    if (!slv_out_valid) begin
                        rsp_last_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                        rsp_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        rsp_q.x         <= slv_x;
                        rsp_q.y         <= slv_y;
                        rsp_q.not_valid <= slv_not_valid;
                        rsp_valid_q     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    gnt_q       <= '0;
                    ptr_q       <= (gnt_idx_q == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                    slv_rst_n_q <= 1'b0;
                    state_q     <= ST_ARM;
                end
                default: begin
                    state_q <= ST_ARM;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign load_en       = load_en_q;
    assign slv_in_valid  = load_en_q;
    assign slv_maze      = req_maze[gnt_idx_q] & load_en_q;
    assign slv_rst_n     = slv_rst_n_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_q.id[ID_W-1:0];
    assign rsp_x         = rsp_q.x;
    assign rsp_y         = rsp_q.y;
    assign rsp_not_valid = rsp_q.not_valid;
    assign rsp_last      = rsp_last_q;
    assign rsp_err       = rsp_err_q;
    assign busy          = busy_q;
    assign id_unused     = ^(rsp_q.id >> ID_W);

endmodule

// File: tb/tb_maze_job_sched.sv
// Bench for maze_job_sched: the bench plays both the requesters and the solver.
// Solver beats are queued as expected responses and popped when rsp_valid appears.
module tb_maze_job_sched;

    localparam int N_REQ     = 4;
    localparam int MAZE_BITS = 225;
    localparam int TIMEOUT   = 1024;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_maze;
    logic [3:0] gnt;
    logic       load_en;
    logic       slv_rst_n;
    logic       slv_maze;
    logic       slv_in_valid;
    logic       slv_out_valid;
    logic       slv_not_valid;
    logic [3:0] slv_x;
    logic [3:0] slv_y;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [3:0] rsp_x;
    logic [3:0] rsp_y;
    logic       rsp_not_valid;
    logic       rsp_last;
    logic       rsp_err;
    logic       busy;

    maze_job_sched #(
        .N_REQ     (N_REQ),
        .MAZE_BITS (MAZE_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_maze      (req_maze),
        .gnt           (gnt),
        .load_en       (load_en),
        .slv_rst_n     (slv_rst_n),
        .slv_maze      (slv_maze),
        .slv_in_valid  (slv_in_valid),
        .slv_out_valid (slv_out_valid),
        .slv_not_valid (slv_not_valid),
        .slv_x         (slv_x),
        .slv_y         (slv_y),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_x         (rsp_x),
        .rsp_y         (rsp_y),
        .rsp_not_valid (rsp_not_valid),
        .rsp_last      (rsp_last),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] x;
        logic [3:0] y;
        logic       nv;
    } beat_t;

    beat_t sb_q[$];
    beat_t mon_e;

    int n_cmp          = 0;
    int n_mis          = 0;
    int cyc            = 0;
    int beats_seen     = 0;
    int ev_cnt         = 0;
    int last_done_cyc  = 0;
    int load_start_cyc = 0;
    int prev_done      = 0;
    int b_stray        = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            beats_seen++;
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_beat", 32'({rsp_id, rsp_x, rsp_y, rsp_not_valid}), 32'(mon_e));
            end
        end
        if (rsp_last || rsp_err) begin
            ev_cnt++;
            chk("last_err_excl", 32'(rsp_last & rsp_err), 0);
        end
    end

    // One full job for requester g; abort_at >= 0 resets the DUT at that load bit instead.
    task automatic run_job(input int g, input bit drop, input int nbeats, input bit nv,
                           input int delay, input bit hang, input int abort_at);
        int    nwait;
        int    nload;
        int    bad;
        int    t_wait0;
        int    c_end;
        int    nend;
        int    ev0;
        int    b0;
        beat_t b;

        nwait = 0;
        while (gnt == 4'b0 && nwait < 20) begin
            step();
            nwait++;
        end
        chk("gnt_latency", nwait, 1);
        chk("gnt_onehot", 32'(gnt), 32'(1) << g);
        if (gnt == 4'b0) return;
        load_start_cyc = cyc;
        if (drop) req[g] = 1'b0;

        nload = 0;
        bad   = 0;
        while (load_en && nload < MAZE_BITS + 10) begin
            if (nload == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_gnt", 32'(gnt), 0);
                chk("abort_load_en", 32'(load_en), 0);
                chk("abort_slv_rst_n", 32'(slv_rst_n), 0);
                ev0 = ev_cnt;
                b0  = beats_seen;
                step();
                rst = 1'b0;
                req_maze = '0;
                step();
                step();
                step();
                chk("abort_no_rsp", ev_cnt - ev0, 0);
                chk("abort_no_beat", beats_seen - b0, 0);
                return;
            end
            req_maze = 4'($urandom);
            #1;
            if (slv_maze !== req_maze[g] || slv_in_valid !== 1'b1) bad++;
            nload++;
            step();
        end
        req_maze = '0;
        chk("load_len", nload, MAZE_BITS);
        chk("load_bits", bad, 0);
        chk("in_valid_low", 32'(slv_in_valid), 0);

        t_wait0 = cyc;
        c_end   = cyc;
        if (!hang) begin
            repeat (delay) step();
            for (int k = 0; k < nbeats; k++) begin
                b.id = 2'(g);
                b.x  = 4'($urandom);
                b.y  = 4'($urandom);
                b.nv = nv;
                slv_out_valid = 1'b1;
                slv_x         = b.x;
                slv_y         = b.y;
                slv_not_valid = nv;
                sb_q.push_back(b);
                c_end = cyc;
                step();
            end
            slv_out_valid = 1'b0;
            slv_x         = '0;
            slv_y         = '0;
            slv_not_valid = 1'b0;
        end

        nend = 0;
        while (!rsp_last && !rsp_err && nend < TIMEOUT + 20) begin
            step();
            nend++;
        end
        chk("end_kind", 32'({rsp_last, rsp_err}), hang ? 1 : 2);
        if (!rsp_last && !rsp_err) return;
        if (hang) begin
            chk("wdog_time", cyc - t_wait0, TIMEOUT);
            chk("err_id", 32'(rsp_id), g);
        end else begin
            chk("last_time", cyc - c_end, 2);
            chk("sb_drained", sb_q.size(), 0);
        end
        last_done_cyc = cyc;
        chk("gnt_in_done", 32'(gnt), 32'(1) << g);
        step();
        chk("arm_slv_rst_n", 32'(slv_rst_n), 0);
        chk("arm_gnt", 32'(gnt), 0);
        step();
        chk("idle_slv_rst_n", 32'(slv_rst_n), 1);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        rst           = 1'b1;
        req           = '0;
        req_maze      = '0;
        slv_out_valid = 1'b0;
        slv_not_valid = 1'b0;
        slv_x         = '0;
        slv_y         = '0;
        step();
        step();
        chk("rst_outputs", 32'({gnt, load_en, slv_in_valid, slv_maze, rsp_valid, rsp_last,
                                rsp_err, busy, rsp_id, rsp_x, rsp_y, rsp_not_valid}), 0);
        chk("rst_slv_rst_n", 32'(slv_rst_n), 0);
        rst = 1'b0;
        step();
        chk("arm_exit_slv_rst_n", 32'(slv_rst_n), 1);
        chk("arm_exit_busy", 32'(busy), 0);

        // Single job from requester 2
        req[2] = 1'b1;
        run_job(2, 1'b1, 3, 1'b0, 5, 1'b0, -1);

        // Solver chatter while idle must not leak out
        b_stray = beats_seen;
        slv_out_valid = 1'b1;
        step();
        step();
        slv_out_valid = 1'b0;
        step();
        step();
        chk("stray_ignored", beats_seen - b_stray, 0);

        // Fairness from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) run_job(k, 1'b0, 2, 1'b0, 1, 1'b0, -1);
        req = 4'b1001;
        run_job(0, 1'b0, 1, 1'b0, 0, 1'b0, -1);
        run_job(3, 1'b0, 1, 1'b0, 0, 1'b0, -1);
        req = '0;

        // Unsolvable maze
        req[1] = 1'b1;
        run_job(1, 1'b1, 2, 1'b1, 3, 1'b0, -1);

        // Solver never answers
        req[3] = 1'b1;
        run_job(3, 1'b1, 0, 1'b0, 0, 1'b1, -1);

        // Back-to-back jobs from one requester
        req[0] = 1'b1;
        run_job(0, 1'b1, 4, 1'b0, 2, 1'b0, -1);
        prev_done = last_done_cyc;
        req[0] = 1'b1;
        run_job(0, 1'b1, 2, 1'b0, 0, 1'b0, -1);
        chk("b2b_gap", load_start_cyc - prev_done, 3);

        // Reset during LOAD, then a clean re-request
        req[2] = 1'b1;
        run_job(2, 1'b1, 0, 1'b0, 0, 1'b0, 100);
        req[2] = 1'b1;
        run_job(2, 1'b1, 3, 1'b0, 4, 1'b0, -1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
